// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming frame parity checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest word the reduction helper accepts; callers zero-extend, which leaves XOR unchanged.
    localparam int unsigned PAR_MAX_W = 1024;

    function automatic logic word_parity(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates parity over a FRAME_LEN-word frame and reports it, with a mismatch flag and a
// saturating count of mismatching frames.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned BCW = $clog2(FRAME_LEN + 1);
    localparam logic [BCW-1:0] LAST_CNT = BCW'(FRAME_LEN - 1);

    state_e         state_q, state_d;
    logic           acc_q, acc_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic           mode_q, mode_d;
    logic           par_in_q, par_in_d;
    logic           out_par_q, out_par_d;
    logic           err_inc;

    logic beat;
    logic word_par;
    logic frame_mode;
    logic frame_par;

    assign word_par = word_parity(PAR_MAX_W'(in_data));
    assign beat     = in_valid && in_ready;

    // The closing beat is the first one in IDLE only when FRAME_LEN is 1; mode comes from the
    // live input in that case and from the latched copy otherwise.
    assign frame_mode = (state_q == IDLE) ? odd_mode : mode_q;
    assign frame_par  = ((state_q == IDLE) ? word_par : (acc_q ^ word_par))
                        ^ (frame_mode == PAR_ODD);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        mode_d     = mode_q;
        par_in_d   = par_in_q;
        out_par_d  = out_par_q;
        err_inc    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_clear) begin
                    acc_d      = 1'b0;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    mode_d = odd_mode;
                    if (FRAME_LEN == 1) begin
                        par_in_d   = in_par;
                        out_par_d  = frame_par;
                        err_inc    = (in_par != frame_par);
                        acc_d      = 1'b0;
                        beat_cnt_d = '0;
                        state_d    = REPORT;
                    end else begin
                        acc_d      = word_par;
                        beat_cnt_d = BCW'(1);
                        state_d    = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_clear) begin
                    acc_d      = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (beat) begin
                    if (beat_cnt_q == LAST_CNT) begin
                        par_in_d   = in_par;
                        out_par_d  = frame_par;
                        err_inc    = (in_par != frame_par);
                        acc_d      = 1'b0;
                        beat_cnt_d = '0;
                        state_d    = REPORT;
                    end else begin
                        acc_d      = acc_q ^ word_par;
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            REPORT: begin
                if (in_clear || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= 1'b0;
            beat_cnt_q <= '0;
            mode_q     <= PAR_EVEN;
            par_in_q   <= 1'b0;
            out_par_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            mode_q     <= mode_d;
            par_in_q   <= par_in_d;
            out_par_q  <= out_par_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_inc),
        .count(err_cnt)
    );

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready  = rst_n && (state_q != REPORT);
    assign out_valid = (state_q == REPORT);
    assign out_par   = out_par_q;
    assign out_err   = par_in_q != out_par_q;

endmodule
